reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/reset_seq_cycle_timer.sv | 36 +++
 rtl/reset_seq.sv | 158 +++++++++++++++
 tb/tb_reset_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// ============================================================================
// Module   : reset_seq_pkg
// Brief    : Shared FSM state encoding, lock-loss count width and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_seq_cycle_timer.sv
// ============================================================================
// Module   : cycle_timer
// Brief    : Loadable down-counter with a done flag; shared by all timed states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             count_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  // Holds at zero once expired so an idle timer never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/reset_seq.sv
// ============================================================================
// Module   : reset_seq
// Brief    : PLL-lock driven staged reset release sequencer with soft reset.
//            Optional macro RESET_SEQ_LOSS_CNT_EN enables lock_loss_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int STABLE_CYC = 1024,
  parameter int GAP_CYC    = 16,
  parameter int STAGES     = 3,
  parameter int HOLD_CYC   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_locked,
  input  logic                  soft_rst,
  output logic [STAGES-1:0]     rst_stage_n,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max3(STABLE_CYC, GAP_CYC, HOLD_CYC)) + 1;

  // Timer is loaded with N-1 at the entry edge so it expires on entry+N.
  localparam logic [CNT_W-1:0] c_stable_ld = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap_ld    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_hold_ld   = CNT_W'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [STAGES-1:0] stage_q, stage_d;
  logic              ready_q, ready_d;
  logic              lost_q, lost_d;
  logic              tmr_load, tmr_count, tmr_done;
  logic [CNT_W-1:0]  tmr_val;

  cycle_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .count_i   (tmr_count),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_LOCK;
      stage_q <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    ready_d   = ready_q;
    lost_d    = lost_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    tmr_val   = '0;

    if (state_q == ST_WAIT_LOCK) begin
      stage_d = '0;
      ready_d = 1'b0;
      if (clk_locked) begin
        state_d  = ST_STABLE;
        tmr_load = 1'b1;
        tmr_val  = c_stable_ld;
      end
    end else if (!clk_locked) begin
      // Lock loss outranks any simultaneous soft reset.
      state_d  = ST_WAIT_LOCK;
      stage_d  = '0;
      ready_d  = 1'b0;
      tmr_load = 1'b1;
      if ((state_q == ST_RELEASE) || (state_q == ST_RUN)) begin
        lost_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_STABLE, ST_HOLD: begin
          if (tmr_done) begin
            state_d  = ST_RELEASE;
            stage_d  = STAGES'(1);
            tmr_load = 1'b1;
            tmr_val  = c_gap_ld;
          end else begin
            tmr_count = 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (soft_rst) begin
            state_d  = ST_HOLD;
            stage_d  = '0;
            ready_d  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = c_hold_ld;
          end else if (state_q == ST_RELEASE) begin
            if (&stage_q) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else if (tmr_done) begin
              stage_d  = (stage_q << 1) | STAGES'(1);
              tmr_load = 1'b1;
              tmr_val  = c_gap_ld;
            end else begin
              tmr_count = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          stage_d = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic                  loss_evt;

  assign loss_evt = !clk_locked && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign rst_stage_n = stage_q;
  assign ready       = ready_q;
  assign lock_lost   = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_seq.sv
// ============================================================================
// Module   : tb_reset_seq
// Brief    : Scoreboard bench for reset_seq; timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_seq;

  localparam int STABLE_CYC = 8;
  localparam int GAP_CYC    = 4;
  localparam int STAGES     = 3;
  localparam int HOLD_CYC   = 5;

  typedef struct packed {
    logic [STAGES-1:0] stage;
    logic              ready;
    logic              lost;
    logic [7:0]        cnt;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              clk_locked;
  logic              soft_rst;
  logic [STAGES-1:0] rst_stage_n;
  logic              ready;
  logic              lock_lost;
  logic [7:0]        lock_loss_cnt;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  reset_seq #(
    .STABLE_CYC(STABLE_CYC),
    .GAP_CYC   (GAP_CYC),
    .STAGES    (STAGES),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_locked   (clk_locked),
    .soft_rst     (soft_rst),
    .rst_stage_n  (rst_stage_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a sequence is an anchor edge plus a lead time (STABLE or HOLD);
  // stage k is released once the edge index reaches anchor+lead+k*GAP.
  int cyc;
  bit m_active;
  int anchor;
  int base;
  bit m_lost;
  int m_cnt;

  task automatic model_step(input bit r, input bit l, input bit s);
    exp_t e;
    bit   released_prev;
    cyc++;
    if (!r) begin
      m_active = 1'b0;
      m_lost   = 1'b0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (l) begin
        m_active = 1'b1;
        anchor   = cyc;
        base     = STABLE_CYC;
      end
    end else begin
      released_prev = ((cyc - 1) >= (anchor + base));
      if (!l) begin
        if (released_prev) begin
          m_lost = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        m_active = 1'b0;
      end else if (s && released_prev) begin
        anchor = cyc;
        base   = HOLD_CYC;
      end
    end
    e = '0;
    for (int k = 0; k < STAGES; k++)
      if (m_active && (cyc >= anchor + base + k * GAP_CYC)) e.stage[k] = 1'b1;
    e.ready = m_active && (cyc >= anchor + base + (STAGES - 1) * GAP_CYC + 1);
    e.lost  = m_lost;
`ifdef RESET_SEQ_LOSS_CNT_EN
    e.cnt   = 8'(m_cnt);
`else
    e.cnt   = 8'd0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit l, input bit s);
    @(negedge clk);
    rst_n      = r;
    clk_locked = l;
    soft_rst   = s;
    @(posedge clk);
    model_step(r, l, s);
  endtask

  task automatic run(input int n, input bit r, input bit l);
    for (int i = 0; i < n; i++) step(r, l, 1'b0);
  endtask

  // Monitor: every cycle is an output beat; pop and compare at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ((rst_stage_n !== e.stage) || (ready !== e.ready) ||
            (lock_lost !== e.lost) || (lock_loss_cnt !== e.cnt)) begin
          n_err++;
          $display("FAIL outputs @edge%0d: got stage=%b ready=%b lost=%b cnt=%0d, want stage=%b ready=%b lost=%b cnt=%0d",
                   cyc, rst_stage_n, ready, lock_lost, lock_loss_cnt,
                   e.stage, e.ready, e.lost, e.cnt);
        end
      end
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cyc        = 0;
    m_active   = 1'b0;
    anchor     = 0;
    base       = 0;
    m_lost     = 1'b0;
    m_cnt      = 0;
    rst_n      = 1'b0;
    clk_locked = 1'b0;
    soft_rst   = 1'b0;

    run(3, 1'b0, 1'b0);
    run(2, 1'b1, 1'b0);

    // Short lock glitch during STABLE, then full sequence to RUN.
    run(5, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run(22, 1'b1, 1'b1);

    // Lock loss in RUN, relock.
    step(1'b1, 1'b0, 1'b0);
    run(22, 1'b1, 1'b1);

    // Soft reset in RUN, then a soft pulse during HOLD that must be ignored.
    step(1'b1, 1'b1, 1'b1);
    run(2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run(14, 1'b1, 1'b1);

    // Soft reset mid-RELEASE.
    step(1'b1, 1'b0, 1'b0);
    run(10, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run(16, 1'b1, 1'b1);

    // rst_n mid-RELEASE, then simultaneous soft reset and lock loss in RUN.
    step(1'b1, 1'b0, 1'b0);
    run(11, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    run(20, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run(20, 1'b1, 1'b1);

    // Saturation of the loss counter.
    for (int i = 0; i < 300; i++) begin
      run(18, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
    end
    run(20, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 19) == 0));

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
